// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer in front of a word-only data memory
//
// Accepts byte/halfword/word loads and stores over a req/ready handshake,
// performs read-merge-write for sub-word stores, extracts and extends
// sub-word load data, and rejects misaligned requests.
//
// Optional macro: ACCESS_CNT_EN enables the dbg_cnt completion counter;
// without it dbg_cnt is tied to zero.
//
// Ports:
//   CLK, RST_n          clock (rising edge), asynchronous active-low reset
//   req / ready         request valid / unit idle and accepting
//   we_req, size,       request: store flag, size (00 b, 01 h, 1x w),
//   sign_ext, addr,     load sign extension, byte address,
//   wdata               right-aligned store data
//   done, rdata,        one-cycle completion pulse, load result,
//   misalign            alignment rejection flag (both held until next accept)
//   mem_A, mem_WD,      word-aligned memory address, write data,
//   mem_WE, mem_RD      write enable, combinational read data
//   dbg_cnt             completed-transaction counter

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              req,
    output logic              ready,
    input  logic              we_req,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD,
    output logic [31:0]       dbg_cnt
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic              we_q;
    logic              misalign_q;

    logic              accept;
    logic              mis_now;
    logic [4:0]        shift;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merged;

    assign accept = req && (state == IDLE);

    // Alignment is judged on the live request; size 11 behaves as a word.
    always_comb begin
        mis_now = 1'b0;
        case (size)
            2'b00:   mis_now = 1'b0;
            2'b01:   mis_now = addr[0];
            default: mis_now = |addr[1:0];
        endcase
    end

    // Lane position in bits; for an aligned half addr_q[0]=0 so this is 0 or 16.
    assign shift      = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_RD >> shift;

    always_comb begin
        load_val = mem_RD;
        case (size_q)
            2'b00:   load_val = {{24{sign_ext_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_val = {{16{sign_ext_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_val = mem_RD;
        endcase
    end

    always_comb begin
        lane_mask = 32'h0000_00FF << shift;
        if (size_q == 2'b01) begin
            lane_mask = 32'h0000_FFFF << shift;
        end
        merged = (word_q & ~lane_mask) | ((wdata_q << shift) & lane_mask);
    end

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mis_now)                 state_nxt = DONE;
                    else if (we_req && size[1])  state_nxt = WRITE;
                    else                         state_nxt = READ;
                end
            end
            READ:    state_nxt = we_q ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state so mem_WE drops the moment reset asserts.
    always_comb begin
        ready  = (state == IDLE);
        done   = (state == DONE);
        mem_WE = (state == WRITE);
        mem_WD = '0;
        if (state == WRITE) begin
            mem_WD = size_q[1] ? wdata_q : merged;
        end
    end

    assign mem_A    = {addr_q[ADDR_W-1:2], 2'b00};
    assign rdata    = rdata_q;
    assign misalign = misalign_q;

    // Request capture and result registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= addr;
                wdata_q    <= wdata;
                size_q     <= size;
                sign_ext_q <= sign_ext;
                we_q       <= we_req;
                misalign_q <= mis_now;
                rdata_q    <= '0;
            end
            if (state == READ) begin
                word_q <= mem_RD;
                if (!we_q) begin
                    rdata_q <= load_val;
                end
            end
        end
    end

`ifdef ACCESS_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else if (state == DONE) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign dbg_cnt = cnt_q;
`else
    assign dbg_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit

module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic        we_req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;
    logic [31:0] dbg_cnt;

    mem_access_unit dut (
        .CLK(CLK), .RST_n(RST_n), .req(req), .ready(ready), .we_req(we_req),
        .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .misalign(misalign), .mem_A(mem_A),
        .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD), .dbg_cnt(dbg_cnt)
    );

    always #5 CLK = ~CLK;

    // Word-only memory seen by the DUT, and the reference image of it.
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    assign mem_RD = mem[mem_A[5:2]];
    always @(posedge CLK) if (mem_WE) mem[mem_A[5:2]] = mem_WD;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] rdata; logic mis; logic chk_rdata; } exp_t;
    typedef struct { int cyc; logic [31:0] a; logic [31:0] d; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    bit mon_en = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    // Reference model: predicts the response and any memory write from the
    // request, using byte counts and masks on the reference memory image.
    task automatic model(input int c, input logic w, input logic [1:0] sz,
                         input logic se, input logic [31:0] a, input logic [31:0] wd);
        int idx, lane, nb;
        logic [63:0] mask, v, m, nw;
        exp_t e;
        wr_t  wr;
        idx  = int'(a[5:2]);
        lane = int'(a[1:0]);
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        e.rdata = '0;
        e.mis = 1'b0;
        e.chk_rdata = 1'b1;
        if ((lane % nb) != 0) begin
            e.mis = 1'b1;
            e.cyc = c + 1;
        end else if (!w) begin
            v = ({32'd0, ref_mem[idx]} >> (8 * lane)) & mask;
            if (se && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e.rdata = v[31:0];
            e.cyc = c + 2;
        end else begin
            e.chk_rdata = 1'b0;
            if (nb == 4) begin
                nw = {32'd0, wd};
                wr.cyc = c + 1;
                e.cyc = c + 2;
            end else begin
                m  = mask << (8 * lane);
                nw = ({32'd0, ref_mem[idx]} & ~m) | (({32'd0, wd} << (8 * lane)) & m);
                wr.cyc = c + 2;
                e.cyc = c + 3;
            end
            ref_mem[idx] = nw[31:0];
            wr.a = {a[31:2], 2'b00};
            wr.d = nw[31:0];
            wr_q.push_back(wr);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares every completion and every memory write.
    always @(negedge CLK) begin
        if (mon_en && RST_n) begin
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("misalign", misalign, e.mis);
                    if (e.chk_rdata) check("rdata", rdata, e.rdata);
                end
            end
            if (mem_WE) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_cycle", cyc, w.cyc);
                    check("write_addr", mem_A, w.a);
                    check("write_data", mem_WD, w.d);
                end
            end
        end
    end

    // Driver: issues one request, then keeps req high with junk while busy.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge CLK);
        check("ready_idle", ready, 1'b1);
        we_req = w; size = sz; sign_ext = se; addr = a; wdata = wd; req = 1'b1;
        model(cyc, w, sz, se, a, wd);
        @(posedge CLK);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!done) begin
                check("ready_busy", ready, 1'b0);
                req = 1'b1; we_req = $urandom; size = $urandom;
                addr = $urandom; wdata = $urandom; sign_ext = $urandom;
            end
        end while (!done && n < 8);
        req = 1'b0;
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;

        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_we", mem_WE, 1'b0);
        check("rst_mem_a", mem_A, 32'd0);
        check("rst_mem_wd", mem_WD, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_dbg_cnt", dbg_cnt, 32'd0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;

        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h55);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        do_req(1'b0, 2'b11, 1'b1, 32'h22, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234ABCD);
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);

        for (int k = 0; k < 300; k++) begin
            do_req(1'(($urandom)), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom);
        end

        repeat (3) @(negedge CLK);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);
`ifdef ACCESS_CNT_EN
        check("dbg_cnt", dbg_cnt, n_done);
`else
        check("dbg_cnt_tied", dbg_cnt, 32'd0);
`endif
        for (int i = 0; i < 16; i++) check("mem_image", mem[i], ref_mem[i]);

        // Reset asserted during the WRITE cycle of a sub-word store.
        mon_en = 1'b0;
        @(negedge CLK);
        we_req = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h25; wdata = 32'h77; req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        check("rst_mid_we_before", mem_WE, 1'b1);
        #2 RST_n = 1'b0;
        #1;
        check("rst_mid_we_after", mem_WE, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        check("rst_mid_mem_kept", mem[9], ref_mem[9]);
        RST_n = 1'b1;
        @(negedge CLK);
        check("rst_rel_ready", ready, 1'b1);
        check("rst_rel_done", done, 1'b0);
        check("rst_rel_dbg_cnt", dbg_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
